// File: rtl/chnl_tx_arbiter.sv
// chnl_tx_arbiter: packet-atomic, round-robin arbiter that shares one RIFFA TX
// channel (AXI-stream, tuser = {tx_last, len}) among C_NUM_SRC producers.
// Packet end is length-driven; tlast is only cross-checked and flagged.
module chnl_tx_arbiter #(
    parameter int C_PCI_DATA_WIDTH = 32,
    parameter int C_NUM_SRC        = 4,
    parameter int C_IDX_W          = 2
) (
    input  logic                                  CLK,
    input  logic                                  RST,
    input  logic [C_NUM_SRC*C_PCI_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [C_NUM_SRC-1:0]                  s_axis_tlast,
    input  logic [C_NUM_SRC-1:0]                  s_axis_tvalid,
    output logic [C_NUM_SRC-1:0]                  s_axis_tready,
    input  logic [C_NUM_SRC*33-1:0]               s_axis_tuser,
    output logic [C_PCI_DATA_WIDTH-1:0]           m_axis_tdata,
    output logic                                  m_axis_tlast,
    output logic                                  m_axis_tvalid,
    input  logic                                  m_axis_tready,
    output logic [32:0]                           m_axis_tuser,
    output logic [C_IDX_W-1:0]                    grant_idx,
    output logic                                  busy,
    output logic                                  err_tlast
);

    localparam int DW  = C_PCI_DATA_WIDTH;
    localparam int WPB = DW / 32;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    state_t               state_q, state_d;
    logic [C_IDX_W-1:0]   grant_q, grant_d;
    logic [C_IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [31:0]          cnt_q, cnt_d;
    logic [31:0]          len_q, len_d;

    logic                 req_any;
    logic [C_IDX_W-1:0]   cand;
    logic [C_IDX_W-1:0]   pick;
    logic [31:0]          pick_len;

    logic [DW-1:0]        src_data;
    logic                 src_last;
    logic                 src_valid;
    logic [32:0]          src_user;
    logic [32:0]          sum_w;
    logic                 final_beat;
    logic                 beat;

    // Round-robin scan starting just after the previous owner
    always_comb begin
        req_any  = 1'b0;
        cand     = '0;
        pick     = '0;
        pick_len = '0;
        for (int unsigned k = 1; k <= 32'(C_NUM_SRC); k++) begin
            cand = C_IDX_W'((32'(rr_ptr_q) + k) % 32'(C_NUM_SRC));
            if (!req_any && s_axis_tvalid[cand]) begin
                req_any = 1'b1;
                pick    = cand;
            end
        end
        for (int unsigned i = 0; i < 32'(C_NUM_SRC); i++) begin
            if (C_IDX_W'(i) == pick) begin
                pick_len = s_axis_tuser[i*33 +: 32];
            end
        end
    end

    // Granted-source mux and beat/final-beat detection (33-bit sum cannot wrap)
    always_comb begin
        src_data  = '0;
        src_last  = 1'b0;
        src_valid = 1'b0;
        src_user  = '0;
        for (int unsigned i = 0; i < 32'(C_NUM_SRC); i++) begin
            if (C_IDX_W'(i) == grant_q) begin
                src_data  = s_axis_tdata[i*DW +: DW];
                src_last  = s_axis_tlast[i];
                src_valid = s_axis_tvalid[i];
                src_user  = s_axis_tuser[i*33 +: 33];
            end
        end
        sum_w      = {1'b0, cnt_q} + 33'(WPB);
        final_beat = (sum_w >= {1'b0, len_q});
        beat       = (state_q == ST_BUSY) && src_valid && m_axis_tready;
    end

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= C_IDX_W'(C_NUM_SRC - 1);
            cnt_q    <= '0;
            len_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
        end
    end

    // Next-state: grant in IDLE, count words per beat in BUSY
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        case (state_q)
            ST_IDLE: begin
                if (req_any) begin
                    state_d = ST_BUSY;
                    grant_d = pick;
                    len_d   = pick_len;
                    cnt_d   = '0;
                end
            end
            ST_BUSY: begin
                if (beat) begin
                    if (final_beat) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = grant_q;
                    end else begin
                        cnt_d = sum_w[31:0];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: pass-through of the owner while busy, everything quiet in IDLE
    always_comb begin
        busy          = (state_q == ST_BUSY);
        grant_idx     = grant_q;
        m_axis_tdata  = src_data;
        m_axis_tlast  = src_last;
        m_axis_tuser  = src_user;
        m_axis_tvalid = (state_q == ST_BUSY) && src_valid;
        s_axis_tready = '0;
        if (state_q == ST_BUSY) begin
            s_axis_tready[grant_q] = m_axis_tready;
        end
        err_tlast     = beat && (src_last != final_beat);
    end

endmodule

// File: tb/tb_chnl_tx_arbiter.sv
// Bench for chnl_tx_arbiter: 32-bit instance checked every cycle against a
// packet-level model, plus a 64-bit instance for length boundary cases.
module tb_chnl_tx_arbiter;

    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int DW2 = 64;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    // 32-bit instance
    logic [N*DW-1:0]  s_tdata;
    logic [N-1:0]     s_tlast, s_tvalid, s_tready;
    logic [N*33-1:0]  s_tuser;
    logic [DW-1:0]    m_tdata;
    logic             m_tlast, m_tvalid, m_tready;
    logic [32:0]      m_tuser;
    logic [1:0]       grant_idx;
    logic             busy, err_tlast;

    // 64-bit instance
    logic [N*DW2-1:0] s2_tdata;
    logic [N-1:0]     s2_tlast, s2_tvalid, s2_tready;
    logic [N*33-1:0]  s2_tuser;
    logic [DW2-1:0]   m2_tdata;
    logic             m2_tlast, m2_tvalid, m2_tready;
    logic [32:0]      m2_tuser;
    logic [1:0]       grant2;
    logic             busy2, err2;

    chnl_tx_arbiter #(.C_PCI_DATA_WIDTH(DW), .C_NUM_SRC(N), .C_IDX_W(2)) dut (
        .CLK(CLK), .RST(RST),
        .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready), .s_axis_tuser(s_tuser),
        .m_axis_tdata(m_tdata), .m_axis_tlast(m_tlast), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready), .m_axis_tuser(m_tuser),
        .grant_idx(grant_idx), .busy(busy), .err_tlast(err_tlast)
    );

    chnl_tx_arbiter #(.C_PCI_DATA_WIDTH(DW2), .C_NUM_SRC(N), .C_IDX_W(2)) dut64 (
        .CLK(CLK), .RST(RST),
        .s_axis_tdata(s2_tdata), .s_axis_tlast(s2_tlast), .s_axis_tvalid(s2_tvalid),
        .s_axis_tready(s2_tready), .s_axis_tuser(s2_tuser),
        .m_axis_tdata(m2_tdata), .m_axis_tlast(m2_tlast), .m_axis_tvalid(m2_tvalid),
        .m_axis_tready(m2_tready), .m_axis_tuser(m2_tuser),
        .grant_idx(grant2), .busy(busy2), .err_tlast(err2)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural producers feeding the 32-bit instance
    int          src_len  [N];
    int          src_rem  [N];
    int          src_beat [N];
    int          src_pk   [N];
    int          src_npk  [N];
    logic        src_hold [N];
    logic [31:0] src_lmask[N];
    logic        src_umask[N];
    logic [N-1:0] hs;
    logic        rdy_toggle;

    function automatic int beats_for(input int len, input int wpb);
        if (len == 0) return 1;
        return (len + wpb - 1) / wpb;
    endfunction

    task automatic drive_srcs();
        for (int i = 0; i < N; i++) begin
            s_tvalid[i]          = (src_rem[i] > 0) && !src_hold[i];
            s_tdata[i*DW +: DW]  = {8'(i), 8'(src_pk[i]), 16'(src_beat[i])};
            s_tuser[i*33 +: 33]  = {1'b1, 32'(src_len[i])};
            s_tlast[i]           = src_umask[i] ? src_lmask[i][5'(src_beat[i])] : (src_rem[i] == 1);
        end
    endtask

    task automatic start_src(input int i, input int len, input int npk);
        src_len[i]  = len;
        src_npk[i]  = npk;
        src_pk[i]   = 0;
        src_beat[i] = 0;
        src_rem[i]  = beats_for(len, 1);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                src_beat[i]++;
                src_rem[i]--;
                if (src_rem[i] == 0 && src_npk[i] > 1) begin
                    src_npk[i]--;
                    src_pk[i]++;
                    src_beat[i] = 0;
                    src_rem[i]  = beats_for(src_len[i], 1);
                end
            end
        end
        m_tready = rdy_toggle ? ~m_tready : 1'b1;
        drive_srcs();
    endtask

    task automatic wait_idle(input int max_cyc);
        int n;
        logic pending;
        n = 0;
        pending = 1'b1;
        while (pending && n < max_cyc) begin
            step();
            n++;
            pending = busy;
            for (int i = 0; i < N; i++) if (src_rem[i] > 0) pending = 1'b1;
        end
        chk("wait_idle_timeout", 64'(pending), 64'd0);
        step();
    endtask

    // Packet-level model: owner, beats sent, length; final when (beats+1)*1 >= len
    logic        md_busy;
    logic [1:0]  md_own;
    logic [1:0]  md_rr;
    int          md_beats;
    logic [31:0] md_len;
    logic        prev_busy;
    int          cyc_n = 0;
    int          pkt_beat;
    int          gl_idx[$];
    int          gl_cyc[$];
    int          beatl[$];
    int          errl[$];
    logic [31:0] obs[$];

    always @(negedge CLK) begin
        logic ov, fin, hsb, found;
        logic [1:0] c;
        cyc_n++;
        if (RST) begin
            chk("rst_mvalid", 64'(m_tvalid), 64'd0);
            chk("rst_tready", 64'(s_tready), 64'd0);
            chk("rst_busy",   64'(busy),     64'd0);
            chk("rst_grant",  64'(grant_idx), 64'd0);
            chk("rst_err",    64'(err_tlast), 64'd0);
            md_busy   = 1'b0;
            md_own    = 2'd0;
            md_rr     = 2'(N - 1);
            md_beats  = 0;
            md_len    = '0;
            prev_busy = 1'b0;
            hs        = '0;
        end else begin
            chk("busy", 64'(busy), 64'(md_busy));
            if (md_busy) begin
                ov  = s_tvalid[md_own];
                fin = (64'(md_beats) + 64'd1) >= 64'(md_len);
                hsb = ov && m_tready;
                chk("grant",   64'(grant_idx), 64'(md_own));
                chk("mvalid",  64'(m_tvalid),  64'(ov));
                if (ov) begin
                    chk("mdata",  64'(m_tdata), 64'(s_tdata[md_own*DW +: DW]));
                    chk("mlast",  64'(m_tlast), 64'(s_tlast[md_own]));
                    chk("muser",  64'(m_tuser), 64'(s_tuser[md_own*33 +: 33]));
                end
                chk("sready",  64'(s_tready), 64'(m_tready ? (4'b0001 << md_own) : 4'b0000));
                chk("err",     64'(err_tlast), 64'(hsb && (s_tlast[md_own] != fin)));
                if (hsb) begin
                    md_beats++;
                    if (fin) begin
                        md_busy = 1'b0;
                        md_rr   = md_own;
                    end
                end
            end else begin
                chk("idle_mvalid", 64'(m_tvalid), 64'd0);
                chk("idle_sready", 64'(s_tready), 64'd0);
                chk("idle_err",    64'(err_tlast), 64'd0);
                found = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    c = 2'(int'(md_rr) + k);
                    if (!found && s_tvalid[c]) begin
                        found    = 1'b1;
                        md_busy  = 1'b1;
                        md_own   = c;
                        md_len   = s_tuser[c*33 +: 32];
                        md_beats = 0;
                    end
                end
            end
            if (busy && !prev_busy) begin
                gl_idx.push_back(int'(grant_idx));
                gl_cyc.push_back(cyc_n);
                pkt_beat = 0;
            end
            if (busy && m_tvalid && m_tready) begin
                obs.push_back(m_tdata);
                if (err_tlast) errl.push_back(pkt_beat);
                pkt_beat++;
            end
            if (!busy && prev_busy) beatl.push_back(pkt_beat);
            prev_busy = busy;
            hs = s_tvalid & s_tready;
        end
    end

    task automatic clear_logs();
        gl_idx.delete(); gl_cyc.delete(); beatl.delete(); errl.delete(); obs.delete();
    endtask

    task automatic send64(input logic [31:0] len, input int nexp, output int beats, output int errs);
        s2_tuser[32:0]  = {1'b1, len};
        s2_tdata[63:0]  = 64'hA5A5_0000_1234_5678;
        s2_tlast[0]     = (nexp == 1);
        s2_tvalid[0]    = 1'b1;
        beats = 0;
        errs  = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge CLK);
            if (m2_tvalid && m2_tready) begin
                beats++;
                if (err2) errs++;
            end
            @(posedge CLK);
            #1;
            s2_tlast[0] = (beats == nexp - 1);
            if (beats > 0 && !busy2) break;
        end
        s2_tvalid[0] = 1'b0;
        step_quiet();
    endtask

    task automatic step_quiet();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int b, e;
        RST = 1'b1;
        m_tready = 1'b1;
        rdy_toggle = 1'b0;
        for (int i = 0; i < N; i++) begin
            src_len[i] = 0; src_rem[i] = 0; src_beat[i] = 0; src_pk[i] = 0; src_npk[i] = 0;
            src_hold[i] = 1'b0; src_lmask[i] = '0; src_umask[i] = 1'b0;
        end
        drive_srcs();
        s2_tdata = '0; s2_tlast = '0; s2_tvalid = '0; s2_tuser = '0; m2_tready = 1'b1;
        #1;
        chk("init_busy",   64'(busy),     64'd0);
        chk("init_mvalid", 64'(m_tvalid), 64'd0);
        chk("init_grant",  64'(grant_idx), 64'd0);
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;

        // Round-robin with all four requesting, len=4
        clear_logs();
        start_src(0, 4, 2);
        start_src(1, 4, 1);
        start_src(2, 4, 1);
        start_src(3, 4, 1);
        drive_srcs();
        wait_idle(100);
        chk("rr_count", 64'(gl_idx.size()), 64'd5);
        if (gl_idx.size() == 5) begin
            chk("rr_g0", 64'(gl_idx[0]), 64'd0);
            chk("rr_g1", 64'(gl_idx[1]), 64'd1);
            chk("rr_g2", 64'(gl_idx[2]), 64'd2);
            chk("rr_g3", 64'(gl_idx[3]), 64'd3);
            chk("rr_g4", 64'(gl_idx[4]), 64'd0);
            for (int k = 1; k < 5; k++) chk("rr_spacing", 64'(gl_cyc[k] - gl_cyc[k-1]), 64'd5);
            for (int k = 0; k < 5; k++) chk("rr_beats", 64'(beatl[k]), 64'd4);
        end

        // Backpressure: src2 len=8, ready toggling
        clear_logs();
        rdy_toggle = 1'b1;
        start_src(2, 8, 1);
        src_pk[2] = 7;
        drive_srcs();
        wait_idle(100);
        rdy_toggle = 1'b0;
        m_tready = 1'b1;
        chk("bp_count", 64'(obs.size()), 64'd8);
        if (obs.size() == 8) begin
            for (int k = 0; k < 8; k++) chk("bp_data", 64'(obs[k]), 64'({8'd2, 8'd7, 16'(k)}));
        end
        chk("bp_beats", 64'(beatl.size() > 0 ? beatl[0] : -1), 64'd8);

        // tlast mismatch: src1 len=4, tlast on beat 2 only
        clear_logs();
        src_umask[1] = 1'b1;
        src_lmask[1] = 32'b0010;
        start_src(1, 4, 1);
        drive_srcs();
        wait_idle(100);
        src_umask[1] = 1'b0;
        chk("tl_beats", 64'(beatl.size() > 0 ? beatl[0] : -1), 64'd4);
        chk("tl_errs",  64'(errl.size()), 64'd2);
        if (errl.size() == 2) begin
            chk("tl_err0", 64'(errl[0]), 64'd1);
            chk("tl_err1", 64'(errl[1]), 64'd3);
        end

        // Stall of src0 mid-packet while src3 requests
        clear_logs();
        start_src(0, 6, 1);
        drive_srcs();
        for (int n = 0; n < 20 && src_beat[0] < 2; n++) step();
        chk("st_reach", 64'(src_beat[0]), 64'd2);
        src_hold[0] = 1'b1;
        start_src(3, 2, 1);
        drive_srcs();
        step();
        step();
        chk("st_grant",  64'(grant_idx), 64'd0);
        chk("st_busy",   64'(busy),      64'd1);
        chk("st_mvalid", 64'(m_tvalid),  64'd0);
        step();
        step();
        step();
        src_hold[0] = 1'b0;
        drive_srcs();
        wait_idle(100);
        chk("st_count", 64'(gl_idx.size()), 64'd2);
        if (gl_idx.size() == 2) begin
            chk("st_g0",  64'(gl_idx[0]), 64'd0);
            chk("st_g1",  64'(gl_idx[1]), 64'd3);
            chk("st_gap", 64'(gl_cyc[1] - gl_cyc[0]), 64'd12);
            chk("st_b0",  64'(beatl[0]), 64'd6);
            chk("st_b1",  64'(beatl[1]), 64'd2);
        end

        // Reset mid-packet, then first grant goes to source 0
        start_src(1, 8, 1);
        drive_srcs();
        for (int n = 0; n < 20 && src_beat[1] < 3; n++) step();
        #3 RST = 1'b1;
        #1;
        chk("ar_mvalid", 64'(m_tvalid), 64'd0);
        chk("ar_sready", 64'(s_tready), 64'd0);
        chk("ar_busy",   64'(busy),     64'd0);
        for (int i = 0; i < N; i++) begin
            src_rem[i] = 0; src_npk[i] = 0; src_beat[i] = 0;
        end
        drive_srcs();
        step();
        step();
        RST = 1'b0;
        clear_logs();
        start_src(2, 1, 1);
        start_src(0, 1, 1);
        drive_srcs();
        wait_idle(100);
        chk("ar_count", 64'(gl_idx.size()), 64'd2);
        if (gl_idx.size() == 2) begin
            chk("ar_first",  64'(gl_idx[0]), 64'd0);
            chk("ar_second", 64'(gl_idx[1]), 64'd2);
        end

        // 64-bit boundary lengths
        send64(32'd0, 1, b, e);
        chk("w64_len0_beats", 64'(b), 64'd1);
        chk("w64_len0_errs",  64'(e), 64'd0);
        send64(32'd3, 2, b, e);
        chk("w64_len3_beats", 64'(b), 64'd2);
        chk("w64_len3_errs",  64'(e), 64'd0);
        send64(32'd5, 3, b, e);
        chk("w64_len5_beats", 64'(b), 64'd3);
        chk("w64_len5_errs",  64'(e), 64'd0);

        // Near-wrap length: counter placed just below 2^32
        s2_tuser[32:0] = {1'b1, 32'hFFFF_FFFE};
        s2_tlast[0]    = 1'b0;
        m2_tready      = 1'b0;
        s2_tvalid[0]   = 1'b1;
        step_quiet();
        step_quiet();
        chk("wrap_busy", 64'(busy2), 64'd1);
        @(negedge CLK);
        s2_tlast[0] = 1'b1;
        m2_tready   = 1'b1;
        #1;
        chk("wrap_err_early", 64'(err2), 64'd1);
        force dut64.cnt_q = 32'hFFFF_FFFE;
        #1;
        chk("wrap_err_final", 64'(err2), 64'd0);
        chk("wrap_mvalid",    64'(m2_tvalid), 64'd1);
        @(posedge CLK);
        #1;
        release dut64.cnt_q;
        s2_tvalid[0] = 1'b0;
        chk("wrap_done", 64'(busy2), 64'd0);
        step_quiet();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
